// File: rtl/ct_spsram_1024x144_acc_ctrl.sv
// Access controller for the 1024x144 single-port SRAM: zero-fill after reset, write/read
// arbitration with read anti-starvation, and a 2-entry response FIFO fed by the 1-cycle Q.
module ct_spsram_1024x144_acc_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 144,
   parameter int STARVE_MAX = 4,
   parameter int INIT_EN    = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  wr_vld,
   output logic                  wr_rdy,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_bmask,
   input  logic                  rd_vld,
   output logic                  rd_rdy,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   init_cnt_reg;
   logic                    init_done_reg;
   logic [SC_W-1:0]         starve_cnt_reg;
   logic                    rd_inflight_reg;
   logic [DATA_WIDTH-1:0]   fifo_mem_reg [2];
   logic                    fifo_wptr_reg, fifo_rptr_reg;
   logic [1:0]              fifo_cnt_reg;

   logic       run, pop, credit_ok, starved, force_rd, wr_grant, rd_grant;
   logic [2:0] occ;

   assign run       = (state_reg == ST_RUN);
   assign rsp_vld   = (fifo_cnt_reg != 2'd0);
   assign rsp_data  = fifo_mem_reg[fifo_rptr_reg];
   assign pop       = rsp_vld & rsp_rdy;
   // Occupancy including the read already on its way out of the SRAM.
   assign occ       = {1'b0, fifo_cnt_reg} + {2'b00, rd_inflight_reg} - {2'b00, pop};
   assign credit_ok = (occ < 3'd2);
   assign starved   = (starve_cnt_reg == SC_W'(STARVE_MAX));
   assign force_rd  = run & starved & credit_ok;
   assign wr_rdy    = run & ~force_rd;
   assign rd_rdy    = run & credit_ok & (~wr_vld | force_rd);
   assign wr_grant  = wr_vld & wr_rdy;
   assign rd_grant  = rd_vld & rd_rdy;
   assign init_done = init_done_reg;

   always_comb begin
      state_next = state_reg;
      if (state_reg == ST_INIT && init_cnt_reg == {ADDR_WIDTH{1'b1}})
         state_next = ST_RUN;
   end

   // SRAM port mux; reset holds the macro deselected even though state sits in INIT.
   always_comb begin
      sram_a    = wr_addr;
      sram_d    = wr_data;
      sram_wen  = ~wr_bmask;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      if (!cpurst_b) begin
         sram_wen = '1;
      end else if (state_reg == ST_INIT) begin
         sram_a    = init_cnt_reg;
         sram_d    = '0;
         sram_wen  = '0;
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
      end else if (wr_grant) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
      end else if (rd_grant) begin
         sram_a    = rd_addr;
         sram_wen  = '1;
         sram_cen  = 1'b0;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_reg       <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         init_cnt_reg    <= '0;
         init_done_reg   <= (INIT_EN == 0);
         starve_cnt_reg  <= '0;
         rd_inflight_reg <= 1'b0;
         fifo_wptr_reg   <= 1'b0;
         fifo_rptr_reg   <= 1'b0;
         fifo_cnt_reg    <= 2'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_INIT) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
            if (state_next == ST_RUN)
               init_done_reg <= 1'b1;
         end
         if (!rd_vld || rd_grant)
            starve_cnt_reg <= '0;
         else if (wr_grant && !starved)
            starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
         rd_inflight_reg <= rd_grant;
         if (rd_inflight_reg)
            fifo_wptr_reg <= ~fifo_wptr_reg;
         if (pop)
            fifo_rptr_reg <= ~fifo_rptr_reg;
         fifo_cnt_reg <= fifo_cnt_reg + {1'b0, rd_inflight_reg} - {1'b0, pop};
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
         always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b)
               fifo_mem_reg[gi] <= '0;
            else if (rd_inflight_reg && fifo_wptr_reg == 1'(gi))
               fifo_mem_reg[gi] <= sram_q;
         end
      end
   endgenerate

endmodule

// File: tb/tb_ct_spsram_1024x144_acc_ctrl.sv
// Bench for the SRAM access controller: behavioural 1024x144 SRAM, table of directed
// single-cycle vectors, plus init, starvation, backpressure and mid-operation reset sequences.
module tb_ct_spsram_1024x144_acc_ctrl;

   localparam logic [143:0] ZERO   = '0;
   localparam logic [143:0] ONES   = '1;
   localparam logic [143:0] A5     = {18{8'hA5}};
   localparam logic [143:0] LOWFF  = 144'hFF;
   localparam logic [143:0] NOT_FF = ~LOWFF;

   logic         clk, cpurst_b;
   logic         wr_vld, wr_rdy, rd_vld, rd_rdy, rsp_vld, rsp_rdy, init_done;
   logic [9:0]   wr_addr, rd_addr, sram_a;
   logic [143:0] wr_data, wr_bmask, rsp_data, sram_wen, sram_d, sram_q;
   logic         sram_cen, sram_gwen;

   int n_cmp = 0;
   int n_bad = 0;

   ct_spsram_1024x144_acc_ctrl dut (
      .forever_cpuclk(clk), .cpurst_b(cpurst_b),
      .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bmask(wr_bmask),
      .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
      .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
      .sram_d(sram_d), .sram_q(sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: active-low controls, per-bit write enable, Q one cycle after a read.
   logic [143:0] mem [1024];
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= mem[sram_a];
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Release reset and walk the zero-fill; init_done must rise on the 1024th edge.
   task automatic run_init(input string tag);
      int bad_rdy = 0;
      int bad_a   = 0;
      int done_at = -1;
      @(posedge clk); #1;
      cpurst_b = 1'b1;
      wr_vld = 1'b1;
      rd_vld = 1'b1;
      #1;
      chkw({tag, "_start_addr"}, {134'd0, sram_a}, ZERO);
      chk1({tag, "_start_cen"}, sram_cen, 1'b0);
      chk1({tag, "_start_gwen"}, sram_gwen, 1'b0);
      for (int k = 1; k <= 1024; k++) begin
         @(posedge clk); #1;
         if (init_done && done_at < 0) done_at = k;
         if (k < 1024) begin
            if (wr_rdy || rd_rdy) bad_rdy++;
            if (sram_a != 10'(k) || sram_cen !== 1'b0) bad_a++;
         end
         if (k == 1023) begin
            wr_vld = 1'b0;
            rd_vld = 1'b0;
         end
      end
      chki({tag, "_done_cycle"}, done_at, 1024);
      chki({tag, "_rdy_during_init"}, bad_rdy, 0);
      chki({tag, "_addr_sequence"}, bad_a, 0);
      $display("%s: zero-fill finished, init_done=%b", tag, init_done);
   endtask

   typedef struct {
      logic         wv;
      logic [9:0]   wa;
      logic [143:0] wd;
      logic [143:0] wm;
      logic         rv;
      logic [9:0]   ra;
      logic         rr;
      logic         e_wrdy;
      logic         e_rrdy;
      logic         e_cen;
      logic         e_rvld;
      logic [143:0] e_data;
   } vec_t;

   vec_t vt [12];

   initial begin
      int acc;
      logic [9:0] bp_addr [3];

      //          wv    wa      wd     wm     rv    ra      rr    wrdy  rrdy  cen   rvld  data
      vt[0]  = '{1'b1, 10'h005, A5,   ONES,  1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZERO};
      vt[1]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b1, 10'h005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ZERO};
      vt[2]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ZERO};
      vt[3]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A5};
      vt[4]  = '{1'b1, 10'h010, ONES, ONES,  1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZERO};
      vt[5]  = '{1'b1, 10'h010, ZERO, LOWFF, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ZERO};
      vt[6]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b1, 10'h010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ZERO};
      vt[7]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ZERO};
      vt[8]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, NOT_FF};
      vt[9]  = '{1'b0, 10'h000, ZERO, ZERO,  1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ZERO};
      vt[10] = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ZERO};
      vt[11] = '{1'b0, 10'h000, ZERO, ZERO,  1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ZERO};

      cpurst_b = 1'b0;
      wr_vld = 1'b0; wr_addr = '0; wr_data = '0; wr_bmask = '0;
      rd_vld = 1'b0; rd_addr = '0; rsp_rdy = 1'b0;

      // Reset values
      #2;
      chk1("rst_rsp_vld", rsp_vld, 1'b0);
      chk1("rst_wr_rdy", wr_rdy, 1'b0);
      chk1("rst_rd_rdy", rd_rdy, 1'b0);
      chk1("rst_cen", sram_cen, 1'b1);
      chk1("rst_gwen", sram_gwen, 1'b1);
      chkw("rst_wen", sram_wen, ONES);
      chk1("rst_init_done", init_done, 1'b0);
      chkw("rst_rsp_data", rsp_data, ZERO);

      run_init("init");

      // Directed single-cycle vectors
      for (int i = 0; i < 12; i++) begin
         wr_vld = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_bmask = vt[i].wm;
         rd_vld = vt[i].rv; rd_addr = vt[i].ra; rsp_rdy = vt[i].rr;
         #1;
         chk1($sformatf("vec%0d_wr_rdy", i), wr_rdy, vt[i].e_wrdy);
         chk1($sformatf("vec%0d_rd_rdy", i), rd_rdy, vt[i].e_rrdy);
         chk1($sformatf("vec%0d_cen", i), sram_cen, vt[i].e_cen);
         chk1($sformatf("vec%0d_rsp_vld", i), rsp_vld, vt[i].e_rvld);
         if (vt[i].e_rvld) chkw($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].e_data);
         $display("vec %0d: wv=%b rv=%b wr_rdy=%b rd_rdy=%b rsp_vld=%b", i, vt[i].wv, vt[i].rv,
                  wr_rdy, rd_rdy, rsp_vld);
         @(posedge clk); #1;
      end

      // Write stream vs. pending read: read forced on the 5th cycle
      wr_vld = 1'b1; wr_addr = 10'h100; wr_data = '0; wr_bmask = ONES;
      rd_vld = 1'b1; rd_addr = 10'h005; rsp_rdy = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         #1;
         chk1($sformatf("starve_c%0d_wr_rdy", c), wr_rdy, c != 5);
         chk1($sformatf("starve_c%0d_rd_rdy", c), rd_rdy & rd_vld, c == 5);
         $display("starve cycle %0d: wr_rdy=%b rd_rdy=%b", c, wr_rdy, rd_rdy);
         @(posedge clk); #1;
         if (c == 5) rd_vld = 1'b0;
      end
      wr_vld = 1'b0;
      #1;
      chk1("starve_rsp_vld", rsp_vld, 1'b1);
      chkw("starve_rsp_data", rsp_data, A5);
      @(posedge clk); #1;

      // Back-to-back reads with the consumer stalled: only two accepted
      bp_addr[0] = 10'h005; bp_addr[1] = 10'h010; bp_addr[2] = 10'h3FF;
      acc = 0;
      rsp_rdy = 1'b0;
      rd_vld = 1'b1;
      for (int c = 0; c < 6; c++) begin
         rd_addr = bp_addr[acc < 3 ? acc : 2];
         #1;
         if (rd_rdy) acc++;
         $display("backpressure cycle %0d: rd_rdy=%b accepted=%0d", c, rd_rdy, acc);
         @(posedge clk); #1;
      end
      chki("bp_accepted", acc, 2);
      rd_vld = 1'b0;
      rsp_rdy = 1'b1;
      #1;
      chk1("bp_rsp0_vld", rsp_vld, 1'b1);
      chkw("bp_rsp0_data", rsp_data, A5);
      @(posedge clk); #1;
      chk1("bp_rsp1_vld", rsp_vld, 1'b1);
      chkw("bp_rsp1_data", rsp_data, NOT_FF);
      @(posedge clk); #1;
      chk1("bp_drained", rsp_vld, 1'b0);

      // Reset while one response is queued and another read is in flight
      rsp_rdy = 1'b0;
      rd_vld = 1'b1; rd_addr = 10'h005;
      @(posedge clk); #1;
      rd_addr = 10'h010;
      @(posedge clk); #1;
      rd_vld = 1'b0;
      chk1("mid_pre_rsp_vld", rsp_vld, 1'b1);
      cpurst_b = 1'b0;
      #1;
      chk1("mid_rsp_vld", rsp_vld, 1'b0);
      chk1("mid_cen", sram_cen, 1'b1);
      chk1("mid_init_done", init_done, 1'b0);
      chk1("mid_wr_rdy", wr_rdy, 1'b0);
      run_init("reinit");
      #1;
      chk1("reinit_rsp_vld", rsp_vld, 1'b0);
      rd_vld = 1'b1; rd_addr = 10'h005; rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rd_vld = 1'b0;
      @(posedge clk); #1;
      chk1("reinit_read_vld", rsp_vld, 1'b1);
      chkw("reinit_read_zero", rsp_data, ZERO);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ct_spsram_1024x144_acc_ctrl.md
Name: ct_spsram_1024x144_acc_ctrl

Overview:
- Access controller sitting directly upstream of the 1024x144 single-port FPGA SRAM model.
- After reset it clears every entry to zero. It then arbitrates a write request port and a read request port onto the SRAM's active-low CEN/GWEN/WEN interface.
- It captures the 1-cycle-latency Q into a 2-entry response FIFO with valid/ready backpressure.
- It guarantees reads are never starved by a continuous write stream.

Parameters:
ADDR_WIDTH, 10, SRAM address width (depth 2^ADDR_WIDTH)
DATA_WIDTH, 144, data word width
STARVE_MAX, 4, consecutive cycles a pending read may lose arbitration before it is forced
INIT_EN, 1, 1 = zero-fill the SRAM after reset; 0 = enter RUN immediately

Ports:
forever_cpuclk  in  1  clock, also drives SRAM CLK
cpurst_b  in  1  asynchronous active-low reset
wr_vld  in  1  write request valid
wr_rdy  out  1  write request accepted this cycle when wr_vld&wr_rdy
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_bmask  in  DATA_WIDTH  active-high bit write mask (1 = write bit)
rd_vld  in  1  read request valid
rd_rdy  out  1  read request accepted when rd_vld&rd_rdy
rd_addr  in  ADDR_WIDTH  read address
rsp_vld  out  1  read response valid
rsp_rdy  in  1  response consumer ready
rsp_data  out  DATA_WIDTH  read response data (FIFO head)
init_done  out  1  1 once zero-fill complete
sram_a  out  ADDR_WIDTH  to SRAM A
sram_cen  out  1  to SRAM CEN, active low
sram_gwen  out  1  to SRAM GWEN, active low
sram_wen  out  DATA_WIDTH  to SRAM WEN, active low per bit
sram_d  out  DATA_WIDTH  to SRAM D
sram_q  in  DATA_WIDTH  from SRAM Q

Behaviour:
Reset values:
- FSM=INIT (RUN if INIT_EN=0); init counter=0; FIFO empty; rsp_vld=0; rsp_data=0.
- init_done=0 (1 if INIT_EN=0); starve counter=0; rd_inflight=0.
- wr_rdy=rd_rdy=0; sram_cen=1, sram_gwen=1, sram_wen=all 1.

FSM INIT:
- Each cycle drives sram_cen=0, sram_gwen=0, sram_wen=0, sram_d=0, sram_a=init counter, then increments the counter.
- After writing address 2^ADDR_WIDTH-1, transitions to RUN; init_done=1 from the next cycle.
- wr_rdy=rd_rdy=0 throughout INIT.

FSM RUN, outputs combinational from requests and state:
- wr_grant = wr_vld & !force_rd.
- rd_grant = rd_vld & credit_ok & (!wr_vld | force_rd).
- force_rd = (starve_cnt == STARVE_MAX) & credit_ok.
- wr_rdy = !force_rd; rd_rdy = credit_ok & (!wr_vld | force_rd).
- Write grant: sram_cen=0, sram_gwen=0, sram_wen=~wr_bmask, sram_a=wr_addr, sram_d=wr_data.
- Read grant: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=rd_addr.
- No grant: sram_cen=1; sram_a/sram_d/sram_wen don't-care, but driven from wr_* for lint stability.

starve_cnt:
- Increments (saturating at STARVE_MAX) when rd_vld & !rd_grant & wr_grant.
- Clears on rd_grant or !rd_vld.

Read latency and capture:
- rd_inflight <= rd_grant.
- When rd_inflight=1, sram_q is pushed into the FIFO that cycle.
- Earliest rsp_vld is 2 cycles after the read handshake cycle.

Credit and FIFO:
- credit_ok = (fifo_cnt + rd_inflight - pop) < 2, where pop = rsp_vld & rsp_rdy.
- FIFO never overflows.
- Simultaneous push and pop leaves the count unchanged and preserves order.
- rsp_vld = fifo_cnt != 0; rsp_data = head entry.

Ordering:
- Single-port, in-order issue: a read granted in the cycle after a write to the same address returns the new data.
- Write and read are never granted in the same cycle.

Reset mid-operation:
- Asynchronous clear of all state; any in-flight read is dropped and the FIFO is emptied.
- Zero-fill restarts from address 0.

Test Plan:
- Reset with INIT_EN=1 -> init_done rises exactly 1024 cycles after reset release; reading addr 0x3FF returns 0; wr_rdy/rd_rdy stay 0 during INIT.
- Write addr 0x005 data 0xA5..A5 with full mask, then a read of 0x005 next cycle -> rsp_vld 2 cycles after the read handshake, rsp_data=0xA5..A5.
- Partial write with wr_bmask=0x00..0FF onto word 0xFF..FF, data 0 -> readback 0xFF..FF00.
- Continuous wr_vld with rd_vld held high, STARVE_MAX=4 -> read granted on the 5th cycle (wr_rdy=0 that cycle); no more than 4 consecutive losses.
- rsp_rdy=0 while issuing reads back-to-back -> exactly 2 reads accepted, then rd_rdy=0; raising rsp_rdy returns data in order with no loss or duplication.
- Assert cpurst_b low while a read is in flight with FIFO count 1 -> rsp_vld=0 immediately, sram_cen=1, INIT restarts at addr 0.
